// File: rtl/ram_dump_reader_pkg.sv
// ram_dump_reader_pkg
//   Shared definitions for the RAM dump reader: FSM state encodings,
//   byte-order constants, widths and the byte-selection helper used by
//   the word serializer.
package ram_dump_reader_pkg;

    // FSM states of the dump reader
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_HI   = 3'd3,
        ST_LO   = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    // Byte-order selectors for MSB_FIRST
    localparam logic ORDER_MSB_FIRST = 1'b1;
    localparam logic ORDER_LSB_FIRST = 1'b0;

    // Width of the word count / remaining counter
    localparam int COUNT_W = 15;

    // Pick the first (second=0) or second (second=1) byte of a word
    // according to the configured byte order.
    function automatic logic [7:0] pick_byte(input logic [15:0] word,
                                             input logic        msb_first,
                                             input logic        second);
        logic take_hi;
        take_hi = msb_first ^ second;
        if (take_hi) begin
            return word[15:8];
        end else begin
            return word[7:0];
        end
    endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// word_byte_serializer
//   Holds one 16-bit RAM word and presents it as two bytes in the order
//   chosen by MSB_FIRST. The output byte is registered so it stays stable
//   while the downstream sink stalls.
// Ports:
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset
//   load      in   capture word_in and present its first byte
//   word_in   in   16-bit word from RAM
//   advance   in   present the second byte of the held word
//   byte_out  out  currently presented byte
module word_byte_serializer
    import ram_dump_reader_pkg::*;
#(
    parameter logic MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] word_in,
    input  logic        advance,
    output logic [7:0]  byte_out
);

    logic [15:0] word_r;
    logic [7:0]  byte_r;

    // Word buffer and presented byte; the buffer is written only on load,
    // so RAM data changing during byte transmission has no effect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_r <= 16'h0000;
            byte_r <= 8'h00;
        end else if (load) begin
            word_r <= word_in;
            byte_r <= pick_byte(word_in, MSB_FIRST, 1'b0);
        end else if (advance) begin
            byte_r <= pick_byte(word_r, MSB_FIRST, 1'b1);
        end else begin
            byte_r <= byte_r;
        end
    end

    assign byte_out = byte_r;

endmodule

// File: rtl/ram_dump_reader.sv
// ram_dump_reader
//   Read-side master for the 16K x 16 RAM. On start it reads count words
//   from base_addr upward (wrapping at the top of the address space) and
//   streams each word as two bytes over a valid/ready byte interface.
//   It never writes the RAM.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, abort        transfer request (IDLE only) / cancel
//   base_addr, count    first word address and word count, captured on start
//   busy, done          transfer in progress / one-cycle completion pulse
//   ram_addr, ram_load  RAM word address / write enable (tied 0)
//   ram_out             RAM read data, valid one cycle after ram_addr
//   tx_data, tx_valid   byte stream out
//   tx_ready            sink ready
module ram_dump_reader
    import ram_dump_reader_pkg::*;
#(
    parameter int   ADDR_W    = 14,
    parameter int   DATA_W    = 16,
    parameter logic MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_load,
    input  logic [DATA_W-1:0]  ram_out,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready
);

    state_t             state_r;
    state_t             next_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [COUNT_W-1:0] rem_r;
    logic               busy_r;
    logic               done_r;
    logic               tx_valid_r;
    logic               hs_s;
    logic               load_s;
    logic               advance_s;

    // Next-state logic plus serializer strobes
    always_comb begin
        next_s    = state_r;
        hs_s      = tx_valid_r & tx_ready;
        load_s    = 1'b0;
        advance_s = 1'b0;
        if (abort && (state_r != ST_IDLE)) begin
            next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // abort beats start when both arrive in IDLE
                    if (start && !abort) begin
                        if (count == 15'd0) begin
                            next_s = ST_FIN;
                        end else begin
                            next_s = ST_ADDR;
                        end
                    end else begin
                        next_s = ST_IDLE;
                    end
                end
                ST_ADDR: next_s = ST_WAIT;
                ST_WAIT: begin
                    load_s = 1'b1;
                    next_s = ST_HI;
                end
                ST_HI: begin
                    if (hs_s) begin
                        advance_s = 1'b1;
                        next_s    = ST_LO;
                    end else begin
                        next_s = ST_HI;
                    end
                end
                ST_LO: begin
                    if (hs_s) begin
                        if (rem_r == 15'd1) begin
                            next_s = ST_FIN;
                        end else begin
                            next_s = ST_ADDR;
                        end
                    end else begin
                        next_s = ST_LO;
                    end
                end
                ST_FIN:  next_s = ST_IDLE;
                default: next_s = ST_IDLE;
            endcase
        end
    end

    // State register and outputs registered from the next state, so
    // busy/done/tx_valid line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tx_valid_r <= 1'b0;
        end else begin
            state_r    <= next_s;
            busy_r     <= (next_s == ST_ADDR) || (next_s == ST_WAIT) ||
                          (next_s == ST_HI)   || (next_s == ST_LO);
            done_r     <= (next_s == ST_FIN);
            tx_valid_r <= (next_s == ST_HI) || (next_s == ST_LO);
        end
    end

    // Address and remaining-word counters; a byte accepted in the abort
    // cycle still advances them, the FSM ends the transfer regardless.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r <= '0;
            rem_r  <= 15'd0;
        end else if ((state_r == ST_IDLE) && (next_s != ST_IDLE)) begin
            addr_r <= base_addr;
            rem_r  <= count;
        end else if ((state_r == ST_LO) && hs_s) begin
            addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            rem_r  <= rem_r - 15'd1;
        end else begin
            addr_r <= addr_r;
            rem_r  <= rem_r;
        end
    end

    word_byte_serializer #(
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load_s),
        .word_in  (ram_out[15:0]),
        .advance  (advance_s),
        .byte_out (tx_data)
    );

    assign busy     = busy_r;
    assign done     = done_r;
    assign tx_valid = tx_valid_r;
    assign ram_addr = addr_r;
    assign ram_load = 1'b0;

endmodule

// File: tb/tb_ram_dump_reader.sv
module tb_ram_dump_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [13:0] base_addr;
    logic [14:0] count;
    logic        tx_ready;

    logic        busy, done, ram_load, tx_valid;
    logic [13:0] ram_addr;
    logic [15:0] ram_out;
    logic [7:0]  tx_data;

    logic        busy2, done2, ram_load2, tx_valid2;
    logic [13:0] ram_addr2;
    logic [15:0] ram_out2;
    logic [7:0]  tx_data2;

    logic [15:0] mem [0:16383];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic [7:0] q[$];
    logic [7:0] q2[$];
    int done_cnt, done_cyc, first_valid_cyc, last_byte_cyc, stall_viol;
    bit ram_load_seen = 1'b0;
    logic pv = 1'b0, pr = 1'b0, pa = 1'b0;
    logic [7:0] pd = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous RAM model: data valid one cycle after the address
    always @(posedge clk) begin
        ram_out  <= mem[ram_addr];
        ram_out2 <= mem[ram_addr2];
    end

    ram_dump_reader #(.ADDR_W(14), .DATA_W(16), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .count(count), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_load(ram_load), .ram_out(ram_out),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready));

    ram_dump_reader #(.ADDR_W(14), .DATA_W(16), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .count(count), .busy(busy2), .done(done2),
        .ram_addr(ram_addr2), .ram_load(ram_load2), .ram_out(ram_out2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready));

    // observer: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (ram_load || ram_load2) ram_load_seen = 1'b1;
        if (!reset_n) begin
            pv = 1'b0;
        end else begin
            if (tx_valid && tx_ready) begin
                q.push_back(tx_data);
                last_byte_cyc = cyc;
            end
            if (tx_valid2 && tx_ready) q2.push_back(tx_data2);
            if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (pv && !pr && !pa) begin
                if (!tx_valid || tx_data !== pd) stall_viol++;
            end
            pv = tx_valid;
            pr = tx_ready;
            pd = tx_data;
            pa = abort;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        q.delete();
        q2.delete();
        done_cnt        = 0;
        done_cyc        = -1;
        first_valid_cyc = -1;
        last_byte_cyc   = -1;
        stall_viol      = 0;
    endtask

    task automatic do_start(input logic [13:0] b, input logic [14:0] c, output int t0);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        count     = c;
        t0        = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        tick(2);
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] got_q[$], input logic [7:0] exp[$]);
        check({tag, "_len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i),
                  (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
        end
    endtask

    initial begin
        int t0;
        int n;
        logic [7:0] e[$];

        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
        mem[14'h0010] = 16'h1234;
        mem[14'h0011] = 16'hABCD;
        mem[14'h0012] = 16'h00FF;
        mem[14'h3FFF] = 16'hBEEF;
        mem[14'h0000] = 16'hCAFE;
        mem[14'h0100] = 16'h0102;
        mem[14'h0101] = 16'h0304;
        mem[14'h0102] = 16'h0506;
        mem[14'h0103] = 16'h0708;
        mem[14'h0104] = 16'h090A;
        mem[14'h0200] = 16'h1111;
        mem[14'h0201] = 16'h2233;
        mem[14'h0202] = 16'h4455;
        mem[14'h0203] = 16'h6677;

        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = 14'h0000;
        count     = 15'd0;
        tx_ready  = 1'b1;
        clear_obs();

        // reset state
        #22;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", tx_valid, 1'b0);
        check("rst_addr", ram_addr, 14'h0000);
        check("rst_data", tx_data, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(2);

        // T1: three words, sink always ready; also the LSB-first build
        clear_obs();
        do_start(14'h0010, 15'd3, t0);
        check("t1_busy", busy, 1'b1);
        wait_done(100);
        e = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
        check_bytes("t1_bytes", q, e);
        e = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00};
        check_bytes("t6_lsb_bytes", q2, e);
        check("t1_first_valid", first_valid_cyc - t0, 32'd3);
        check("t1_last_byte", last_byte_cyc - t0, 32'd12);
        check("t1_done_cyc", done_cyc - t0, 32'd13);
        check("t1_done_cnt", done_cnt, 32'd1);
        check("t1_idle_busy", busy, 1'b0);

        // T2: zero-length transfer
        clear_obs();
        do_start(14'h0010, 15'd0, t0);
        check("t2_busy_fin", busy, 1'b0);
        tick(3);
        check("t2_done_cnt", done_cnt, 32'd1);
        check("t2_done_cyc", done_cyc - t0, 32'd1);
        check("t2_no_valid", first_valid_cyc < 0, 1'b1);

        // T3: address wrap 0x3FFF -> 0x0000
        clear_obs();
        do_start(14'h3FFF, 15'd2, t0);
        wait_done(100);
        e = '{8'hBE, 8'hEF, 8'hCA, 8'hFE};
        check_bytes("t3_bytes", q, e);
        check("t3_done_cnt", done_cnt, 32'd1);

        // T4: sink ready about 30% of cycles
        clear_obs();
        tx_ready = 1'b0;
        do_start(14'h0100, 15'd5, t0);
        n = 0;
        while (done_cnt == 0 && n < 600) begin
            tx_ready = ($urandom_range(0, 99) < 30);
            @(posedge clk);
            #1;
            n++;
        end
        tx_ready = 1'b1;
        tick(2);
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        check_bytes("t4_bytes", q, e);
        check("t4_done_cnt", done_cnt, 32'd1);
        check("t4_stall_stable", stall_viol, 32'd0);
        check("t4_ram_load", ram_load_seen, 1'b0);

        // T5: abort during LO of word 2 of 4, then restart
        clear_obs();
        do_start(14'h0200, 15'd4, t0);
        tick(t0 + 8 - cyc);
        check("t5_valid_lo", tx_valid, 1'b1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_valid", tx_valid, 1'b0);
        tick(6);
        check("t5_no_done", done_cnt, 32'd0);
        e = '{8'h11, 8'h11, 8'h22, 8'h33};
        check_bytes("t5_bytes", q, e);
        clear_obs();
        do_start(14'h0010, 15'd1, t0);
        wait_done(100);
        e = '{8'h12, 8'h34};
        check_bytes("t5_restart", q, e);
        check("t5_restart_done", done_cnt, 32'd1);

        // T6a: start while busy is ignored
        clear_obs();
        do_start(14'h0010, 15'd2, t0);
        start     = 1'b1;
        base_addr = 14'h3FFF;
        count     = 15'd5;
        tick(1);
        start = 1'b0;
        wait_done(100);
        e = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        check_bytes("t6_busy_start", q, e);
        check("t6_done_cyc", done_cyc - t0, 32'd9);
        check("t6_done_cnt", done_cnt, 32'd1);

        // T6b: asynchronous reset while in HI
        clear_obs();
        tx_ready = 1'b0;
        do_start(14'h0010, 15'd3, t0);
        tick(2);
        check("t6_hi_valid", tx_valid, 1'b1);
        check("t6_hi_data", tx_data, 8'h12);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", tx_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_data", tx_data, 8'h00);
        check("t6_rst_addr", ram_addr, 14'h0000);
        check("t6_rst_done", done, 1'b0);
        tx_ready = 1'b1;
        tick(1);
        reset_n = 1'b1;
        tick(4);
        check("t6_post_done", done_cnt, 32'd0);
        check("t6_post_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
